// File: rtl/skolem_chk_pkg.sv
// Shared types and cycle-budget helpers for the Skolem parity sweep checker.
// Macro SKOLEM_FAIL_COUNT_EN (used by the top) selects full-sweep counting versus early stop.
package skolem_chk_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    // Cycles spent walking every assignment, each held SETTLE idle cycles plus one CHECK.
    function automatic int sweep_budget(input int n_in, input int settle);
        return (1 << n_in) * (settle + 1);
    endfunction

    // Cycles from the accepting edge to the done_o pulse on a clean sweep.
    function automatic int sweep_latency(input int n_in, input int settle);
        return 1 + sweep_budget(n_in, settle);
    endfunction

endpackage

// File: rtl/skolem_parity_eval.sv
// Combinational parity check of one candidate Skolem evaluation against the target.
module skolem_parity_eval #(
    parameter int N_IN  = 3,
    parameter int M_OUT = 2
) (
    input  logic [N_IN-1:0]  x,
    input  logic [M_OUT-1:0] y,
    input  logic             target,
    output logic             viol
);

    assign viol = ((^x) ^ (^y)) != target;

endmodule

// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep checker for parity-family Skolem candidates.
// Macro SKOLEM_FAIL_COUNT_EN: defined = full sweep with saturating fail count; undefined = stop at first violation.
module skolem_sweep_checker
    import skolem_chk_pkg::*;
#(
    parameter int   N_IN   = 3,
    parameter int   M_OUT  = 2,
    parameter logic TARGET = 1'b0,
    parameter int   SETTLE = 0,
    parameter int   CNT_W  = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [N_IN-1:0]  x_o,
    input  logic [M_OUT-1:0] y_i,
    output logic [N_IN-1:0]  cex_o,
    output logic [CNT_W-1:0] fail_cnt_o
);

    localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam state_t     AFTER_STEP  = (SETTLE == 0) ? S_CHECK : S_SETTLE;

    state_t           state;
    logic [3:0]       settle_cnt;
    logic             pass_r;
    logic             viol;
    logic             last_x;
    logic             early_stop;
    logic [CNT_W-1:0] cnt_nxt;

    skolem_parity_eval #(
        .N_IN  (N_IN),
        .M_OUT (M_OUT)
    ) u_eval (
        .x      (x_o),
        .y      (y_i),
        .target (TARGET),
        .viol   (viol)
    );

    assign last_x = (x_o == '1);

    always_comb begin
        cnt_nxt    = fail_cnt_o;
        early_stop = 1'b0;
        if (viol) begin
`ifdef SKOLEM_FAIL_COUNT_EN
            if (fail_cnt_o != '1) begin
                cnt_nxt = fail_cnt_o + 1'b1;
            end
`else
            cnt_nxt    = CNT_W'(1);
            early_stop = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            x_o        <= '0;
            cex_o      <= '0;
            fail_cnt_o <= '0;
            pass_r     <= 1'b0;
            settle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        x_o        <= '0;
                        cex_o      <= '0;
                        fail_cnt_o <= '0;
                        pass_r     <= 1'b0;
                        settle_cnt <= '0;
                        state      <= AFTER_STEP;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    fail_cnt_o <= cnt_nxt;
                    // Only the first violation is recorded as the counterexample.
                    if (viol && (fail_cnt_o == '0)) begin
                        cex_o <= x_o;
                    end
                    if (last_x || early_stop) begin
                        pass_r <= (cnt_nxt == '0);
                        state  <= S_FIN;
                    end else begin
                        x_o   <= x_o + 1'b1;
                        state <= AFTER_STEP;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state == S_SETTLE) || (state == S_CHECK);
    assign done_o = (state == S_FIN);
    assign pass_o = pass_r;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Scoreboard bench for skolem_sweep_checker: two instances (SETTLE=0 and SETTLE=2) driven by model candidates.
module tb_skolem_sweep_checker;

    typedef struct {
        time ts;
        int  lat;
        bit  pass;
        int  cex;
        int  cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    int         mode0 = 0, mode1 = 0;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [2:0] x0, x1, cex0, cex1;
    logic [1:0] y0, y1;
    logic [3:0] cnt0, cnt1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Candidate netlists: 0 correct {0,^x}, 1 stuck-at-0, 2 wrong only at x=7.
    function automatic logic [1:0] ycalc(input int m, input logic [2:0] x);
        logic [1:0] y;
        case (m)
            0:       y = {1'b0, ^x};
            1:       y = 2'b00;
            default: y = {1'b0, (^x) ^ (x == 3'b111)};
        endcase
        return y;
    endfunction

    always_comb y0 = ycalc(mode0, x0);
    always_comb y1 = ycalc(mode1, x1);

    skolem_sweep_checker #(.N_IN(3), .M_OUT(2), .TARGET(1'b0), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .x_o(x0), .y_i(y0), .cex_o(cex0), .fail_cnt_o(cnt0)
    );

    skolem_sweep_checker #(.N_IN(3), .M_OUT(2), .TARGET(1'b0), .SETTLE(2)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .x_o(x1), .y_i(y1), .cex_o(cex1), .fail_cnt_o(cnt1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("dut0_latency", int'(($time - e.ts + 5) / 10), e.lat);
                check("dut0_pass", int'(pass0), int'(e.pass));
                check("dut0_cex", int'(cex0), e.cex);
                check("dut0_fail_cnt", int'(cnt0), e.cnt);
                check("dut0_busy_at_done", int'(busy0), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_latency", int'(($time - e.ts + 5) / 10), e.lat);
                check("dut1_pass", int'(pass1), int'(e.pass));
                check("dut1_cex", int'(cex1), e.cex);
                check("dut1_fail_cnt", int'(cnt1), e.cnt);
                check("dut1_busy_at_done", int'(busy1), 0);
            end
        end
    end

    // Returns at the negedge of cycle t+1, where t is the accepting edge.
    task automatic issue(input int d, input int m, input bit push, input int lat,
                         input bit p, input int cx, input int cn);
        exp_t e;
        @(negedge clk);
        if (d == 0) begin mode0 = m; start0 = 1'b1; end
        else        begin mode1 = m; start1 = 1'b1; end
        @(posedge clk);
        e.ts = $time; e.lat = lat; e.pass = p; e.cex = cx; e.cnt = cn;
        if (push) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int k;
        k = 0;
        while ((((d == 0) ? q0.size() : q1.size()) != 0) && (k < 300)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            check((d == 0) ? "dut0_done_timeout" : "dut1_done_timeout", 0, 1);
            if (d == 0) q0.delete();
            else        q1.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        bit   many;
        int   k;
`ifdef SKOLEM_FAIL_COUNT_EN
        many = 1'b1;
`else
        many = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy0", int'(busy0), 0);
        check("rst_done0", int'(done0), 0);
        check("rst_pass0", int'(pass0), 0);
        check("rst_x0", int'(x0), 0);
        check("rst_cex0", int'(cex0), 0);
        check("rst_cnt0", int'(cnt0), 0);
        check("rst_busy1", int'(busy1), 0);
        check("rst_x1", int'(x1), 0);
        rst = 1'b0;
        @(negedge clk);

        // Correct candidate, SETTLE=0
        issue(0, 0, 1'b1, 9, 1'b1, 0, 0);
        check("start_busy0", int'(busy0), 1);
        check("start_x0", int'(x0), 0);
        wait_idle(0);

        // Stuck-at-0 candidate
        if (many) issue(0, 1, 1'b1, 9, 1'b0, 1, 4);
        else      issue(0, 1, 1'b1, 3, 1'b0, 1, 1);
        wait_idle(0);

        // Only x=7 violates: last assignment fails
        issue(0, 2, 1'b1, 9, 1'b0, 7, 1);
        wait_idle(0);

        // SETTLE=2, correct candidate, x_o held three cycles per value
        issue(1, 0, 1'b1, 25, 1'b1, 0, 0);
        check("hold_x1_c1", int'(x1), 0);
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);
            check("hold_x1", int'(x1), (c - 1) / 3);
        end
        wait_idle(1);

        // SETTLE=2, stuck-at-0 candidate
        if (many) issue(1, 1, 1'b1, 25, 1'b0, 1, 4);
        else      issue(1, 1, 1'b1, 7, 1'b0, 1, 1);
        wait_idle(1);

        // Reset mid-sweep: no done, then a fresh sweep
        issue(0, 0, 1'b0, 0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy0", int'(busy0), 0);
        check("midrst_x0", int'(x0), 0);
        check("midrst_done0", int'(done0), 0);
        check("midrst_cnt0", int'(cnt0), 0);
        check("midrst_cex0", int'(cex0), 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_idle_busy0", int'(busy0), 0);
        issue(0, 0, 1'b1, 9, 1'b1, 0, 0);
        wait_idle(0);

        // start pulses while busy and during FIN are ignored
        issue(0, 0, 1'b1, 9, 1'b1, 0, 0);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 0;
        while (!done0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("fin_reached", int'(done0), 1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("fin_start_not_queued_busy", int'(busy0), 0);
        check("fin_start_not_queued_done", int'(done0), 0);
        check("result_hold_pass0", int'(pass0), 1);
        wait_idle(0);
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
